maria_regfile_v2: RTL
=====================

Name: maria_regfile_v2

Overview:
- Parametrised MARIA register bank that succeeds the fixed-size control block. It decodes the MARIA register window and holds the palette colours, DPP pointer, CHARBASE and CTRL registers.
- It generates the WSYNC ready-hold with a timeout.
- It supports readback of every register and selectable CTRL commit timing (immediate, or at line start).
- It sits between the CPU bus and the MARIA line/DMA engines, on clk_sys, qualified by the pclk0 enable.

Parameters:
- NUM_PAL, 8, implemented palettes (1..8); each palette has 3 colours.
- READBACK, 0, 1 = registers read back their value; 0 = only MSTAT reads back, all other registers read 0.
- CTRL_COMMIT, 0, 0 = CTRL takes effect one pclk0 after the write; 1 = CTRL takes effect at the next line_start.
- WSYNC_TIMEOUT, 1024, clk_sys cycles before the ready-hold self-releases; 0 disables the timeout.
- DPP_NTSC, 16'h0084, DPP reset value when bypass_bios=1 and pal=0.
- DPP_PAL, 16'h2730, DPP reset value when bypass_bios=1 and pal=1.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pclk0  in  1  CPU phase enable; all bus accesses are qualified by it.
- maria_en  in  1  0 = 2600 mode; the block is held in its reset state.
- AB  in  16  CPU address.
- DB_in  in  8  CPU write data.
- RW  in  1  1 = read, 0 = write.
- DB_out  out  8  registered read data.
- status_read  in  8  MSTAT value.
- line_start  in  1  one-cycle strobe at the start of each line.
- hsync  in  1  one-cycle strobe at horizontal sync.
- pal  in  1  PAL select (used for the DPP reset value).
- bypass_bios  in  1  selects the DPP reset value.
- ctrl  out  8  active CTRL value.
- color_map  out  8*(1+3*NUM_PAL)  flattened: index 0 = background, index 1+3p+c = palette p, colour c.
- char_base  out  8  CHARBASE.
- zp  out  16  DPP pointer {DPPH, DPPL}.
- ready_hold  out  1  1 = CPU RDY deasserted.
- wsync_timeout  out  1  one-cycle pulse when the ready-hold is released by timeout.

Behaviour:
- Select: sel = maria_en && AB[15:10]==0 && AB[7:5]==3'b001; off = AB[4:0].
- Write (wr): pclk0 && sel && !RW.
- Read (rd): pclk0 && sel && RW.
- Register map (off = 4p + c):
  - off 0 = background.
  - off 4p+c with c in 1..3, p in 0..7 = palette colour; palette p register index 1+3p+(c-1).
  - off 4 = WSYNC (write-only strobe).
  - off 8 = MSTAT (read-only).
  - off 12 = DPPH; off 16 = DPPL; off 20 = CHARBASE; off 24 = reserved; off 28 = CTRL.
  - Palettes with p >= NUM_PAL: writes are ignored, reads return 0.
- Reset values (reset=1 or maria_en=0):
  - ctrl = 8'hFF and shadow CTRL = 8'hFF (DMA off), so the BIOS can be skipped.
  - All colours = 0, char_base = 0, DB_out = 0.
  - zp = bypass_bios ? (pal ? DPP_PAL : DPP_NTSC) : 0.
  - ready_hold = 0, wsync_timeout = 0, timeout counter = 0.
- CTRL:
  - A write loads the shadow register.
  - CTRL_COMMIT=0: ctrl <= shadow on every pclk0, so the new value is visible one pclk0 after the write.
  - CTRL_COMMIT=1: ctrl <= shadow on line_start only.
  - A CTRL write and line_start in the same cycle: the old shadow commits; the new value commits at the next line_start.
- Read data:
  - DB_out is updated on rd only and holds between reads, giving 1 pclk0 latency.
  - MSTAT returns status_read.
  - WSYNC and reserved offsets return 0.
  - Other offsets return the register value if READBACK=1, else 0.
  - CTRL reads return the shadow value.
- WSYNC state machine:
  - IDLE: a write to WSYNC moves to HOLD, sets ready_hold=1 and clears the counter.
  - HOLD: the counter increments each clk_sys cycle.
    - hsync -> IDLE, ready_hold=0.
    - Else, if WSYNC_TIMEOUT != 0 and counter == WSYNC_TIMEOUT-1 -> IDLE, ready_hold=0, wsync_timeout pulses for 1 cycle.
  - A WSYNC write in the same cycle as hsync (from IDLE): the write wins; the hold is released at the next hsync.
  - A write while in HOLD: ignored (the CPU is stalled anyway).
  - The counter saturates and does not wrap.
- maria_en falling mid-HOLD: immediate return to reset state, ready_hold=0.

Decomposition:
- Shared package maria_pkg:
  - register offset localparams (OFF_BKG, OFF_WSYNC, OFF_MSTAT, OFF_DPPH, OFF_DPPL, OFF_CHARBASE, OFF_CTRL);
  - typedef wsync_state_t {IDLE, HOLD};
  - function pal_index(p, c).
- One sub-module, maria_wsync_ctl: the WSYNC FSM and timeout counter. It takes wr_wsync, hsync and clk_sys/reset, and outputs ready_hold and wsync_timeout.

Test Plan:
- Reset with bypass_bios=1, pal=1 -> zp=16'h2730, ctrl=8'hFF, all colours 0, ready_hold=0.
- Write 8'h1E to AB=16'h0125, NUM_PAL=8 -> color_map[4]=8'h1E; with READBACK=1, reading 16'h0025 -> DB_out=8'h1E.
- NUM_PAL=2, write 8'h55 to 16'h0039 -> no colour changes; a read returns 0.
- CTRL_COMMIT=1, write 8'h40 to 16'h003C -> ctrl stays 8'hFF until line_start, then 8'h40; a write coinciding with line_start -> commits at the next line_start.
- Write to 16'h0024 -> ready_hold=1 the next cycle; hsync 300 cycles later -> ready_hold=0, no wsync_timeout pulse.
- WSYNC_TIMEOUT=16, WSYNC write with no hsync -> ready_hold drops after 16 cycles with a single wsync_timeout pulse; maria_en=0 mid-hold -> ready_hold=0 immediately.

Source files
------------

// File: rtl/maria_pkg.sv
// Shared MARIA register-window definitions: offsets, decoded access and WSYNC states.
package maria_pkg;

    localparam int unsigned OFF_W = 5;

    localparam logic [OFF_W-1:0] OFF_BKG      = 5'd0;
    localparam logic [OFF_W-1:0] OFF_WSYNC    = 5'd4;
    localparam logic [OFF_W-1:0] OFF_MSTAT    = 5'd8;
    localparam logic [OFF_W-1:0] OFF_DPPH     = 5'd12;
    localparam logic [OFF_W-1:0] OFF_DPPL     = 5'd16;
    localparam logic [OFF_W-1:0] OFF_CHARBASE = 5'd20;
    localparam logic [OFF_W-1:0] OFF_RSVD     = 5'd24;
    localparam logic [OFF_W-1:0] OFF_CTRL     = 5'd28;

    // DMA off, so a BIOS-less boot starts with a quiet display
    localparam logic [7:0] CTRL_RESET = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } wsync_state_t;

    typedef struct packed {
        logic [OFF_W-1:0] off;
        logic             wr;
        logic             rd;
    } maria_acc_t;

    // Colour-map index of palette p, colour c (c in 1..3): 1 + 3p + (c-1)
    function automatic logic [OFF_W-1:0] pal_index(input logic [2:0] p, input logic [1:0] c);
        return 5'(p) * 5'd3 + 5'(c);
    endfunction

endpackage

// File: rtl/maria_regfile_v2_if.sv
// CPU-side bus of the MARIA register window.
interface maria_regfile_v2_if;
    logic        pclk0;
    logic [15:0] AB;
    logic [7:0]  DB_in;
    logic        RW;
    logic [7:0]  DB_out;

    modport master (output pclk0, AB, DB_in, RW, input DB_out);
    modport slave  (input pclk0, AB, DB_in, RW, output DB_out);
endinterface

// File: rtl/maria_wsync_ctl.sv
// WSYNC ready-hold state machine with optional self-release timeout.
module maria_wsync_ctl
    import maria_pkg::*;
#(
    parameter int unsigned WSYNC_TIMEOUT = 1024
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic maria_en,
    input  logic wr_wsync,
    input  logic hsync,
    output logic ready_hold,
    output logic wsync_timeout
);

    localparam int unsigned CNT_W = (WSYNC_TIMEOUT > 1) ? $clog2(WSYNC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((WSYNC_TIMEOUT == 0) ? 0 : WSYNC_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (WSYNC_TIMEOUT != 0);

    wsync_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_hold_d;
    logic             timeout_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ready_hold    <= 1'b0;
            wsync_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ready_hold    <= ready_hold_d;
            wsync_timeout <= timeout_d;
        end
    end

    // hsync release has priority over the timeout; writes during HOLD are ignored
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready_hold_d = ready_hold;
        timeout_d    = 1'b0;
        if (!maria_en) begin
            state_d      = IDLE;
            cnt_d        = '0;
            ready_hold_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_wsync) begin
                        state_d      = HOLD;
                        cnt_d        = '0;
                        ready_hold_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if (hsync) begin
                        state_d      = IDLE;
                        ready_hold_d = 1'b0;
                    end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                        state_d      = IDLE;
                        ready_hold_d = 1'b0;
                        timeout_d    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/maria_regfile_v2.sv
// MARIA register bank: window decode, palettes, DPP, CHARBASE, CTRL with
// selectable commit timing, registered readback and the WSYNC ready-hold.
module maria_regfile_v2
    import maria_pkg::*;
#(
    parameter int unsigned NUM_PAL       = 8,
    parameter int unsigned READBACK      = 0,
    parameter int unsigned CTRL_COMMIT   = 0,
    parameter int unsigned WSYNC_TIMEOUT = 1024,
    parameter logic [15:0] DPP_NTSC      = 16'h0084,
    parameter logic [15:0] DPP_PAL       = 16'h2730
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    maria_regfile_v2_if.slave             bus,
    input  logic                          maria_en,
    input  logic [7:0]                    status_read,
    input  logic                          line_start,
    input  logic                          hsync,
    input  logic                          pal,
    input  logic                          bypass_bios,
    output logic [7:0]                    ctrl,
    output logic [8*(1+3*NUM_PAL)-1:0]    color_map,
    output logic [7:0]                    char_base,
    output logic [15:0]                   zp,
    output logic                          ready_hold,
    output logic                          wsync_timeout
);

    localparam int unsigned NUM_COLORS = 1 + 3 * NUM_PAL;
    localparam logic [3:0]  NUM_PAL_L  = 4'(NUM_PAL);

    logic [NUM_COLORS-1:0][7:0] color_q;
    logic [7:0]                 shadow_q;
    logic [7:0]                 db_out_q;

    maria_acc_t acc;
    logic       sel;
    logic [2:0] pal_p;
    logic [1:0] pal_c;
    logic       pal_ok;
    logic [4:0] pal_idx;
    logic [15:0] dpp_rst;
    logic       commit;
    logic [7:0] rd_data;
    logic       unused_ab;

    // AB[9:8] are don't-care: the window is mirrored across them
    assign unused_ab = ^bus.AB[9:8];

    assign sel     = maria_en && (bus.AB[15:10] == 6'd0) && (bus.AB[7:5] == 3'b001);
    assign acc.off = bus.AB[4:0];
    assign acc.wr  = bus.pclk0 && sel && !bus.RW;
    assign acc.rd  = bus.pclk0 && sel && bus.RW;

    assign pal_p   = acc.off[4:2];
    assign pal_c   = acc.off[1:0];
    assign pal_ok  = (pal_c != 2'd0) && ({1'b0, pal_p} < NUM_PAL_L);
    assign pal_idx = pal_index(pal_p, pal_c);

    assign dpp_rst = bypass_bios ? (pal ? DPP_PAL : DPP_NTSC) : 16'h0000;
    assign commit  = (CTRL_COMMIT == 0) ? bus.pclk0 : line_start;

    assign color_map  = color_q;
    assign bus.DB_out = db_out_q;

    // Read data source; unimplemented palettes fall through to 0
    always_comb begin
        rd_data = 8'h00;
        if (acc.off == OFF_MSTAT) begin
            rd_data = status_read;
        end else if (READBACK != 0) begin
            if (pal_ok) begin
                for (int unsigned i = 0; i < NUM_COLORS; i++) begin
                    if (pal_idx == 5'(i)) rd_data = color_q[i];
                end
            end else begin
                case (acc.off)
                    OFF_BKG:             rd_data = color_q[0];
                    OFF_DPPH:            rd_data = zp[15:8];
                    OFF_DPPL:            rd_data = zp[7:0];
                    OFF_CHARBASE:        rd_data = char_base;
                    OFF_CTRL:            rd_data = shadow_q;
                    OFF_WSYNC, OFF_RSVD: rd_data = 8'h00;
                    default:             rd_data = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            color_q   <= '0;
            char_base <= 8'h00;
            zp        <= dpp_rst;
            shadow_q  <= CTRL_RESET;
            ctrl      <= CTRL_RESET;
            db_out_q  <= 8'h00;
        end else if (!maria_en) begin
            color_q   <= '0;
            char_base <= 8'h00;
            zp        <= dpp_rst;
            shadow_q  <= CTRL_RESET;
            ctrl      <= CTRL_RESET;
            db_out_q  <= 8'h00;
        end else begin
            // ctrl takes the pre-write shadow, so a coincident write lands one commit later
            if (commit) ctrl <= shadow_q;
            if (acc.rd) db_out_q <= rd_data;
            if (acc.wr) begin
                if (pal_ok) begin
                    for (int unsigned i = 0; i < NUM_COLORS; i++) begin
                        if (pal_idx == 5'(i)) color_q[i] <= bus.DB_in;
                    end
                end else begin
                    case (acc.off)
                        OFF_BKG:      color_q[0] <= bus.DB_in;
                        OFF_DPPH:     zp[15:8]   <= bus.DB_in;
                        OFF_DPPL:     zp[7:0]    <= bus.DB_in;
                        OFF_CHARBASE: char_base  <= bus.DB_in;
                        OFF_CTRL:     shadow_q   <= bus.DB_in;
                        default: ;
                    endcase
                end
            end
        end
    end

    maria_wsync_ctl #(
        .WSYNC_TIMEOUT(WSYNC_TIMEOUT)
    ) u_wsync (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .maria_en     (maria_en),
        .wr_wsync     (acc.wr && (acc.off == OFF_WSYNC)),
        .hsync        (hsync),
        .ready_hold   (ready_hold),
        .wsync_timeout(wsync_timeout)
    );

endmodule
